rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Owns the single write port of the 8x8 register file and shares it between two requesters: A (pipeline writeback stage) and B (debug/load port).
- After reset, first sequences an initialisation pass that writes reg[i] = i for every register, one register per cycle.
- Then arbitrates A/B with valid/ready handshakes and drives registered write-port signals into the register file.

Parameters:
- NUM_REGS, 8, number of registers to initialise and address; must equal 2**REG_ADDR_W.
- REG_ADDR_W, 3, register number width.
- DATA_W, 8, write data width.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- A_Valid  input  1  requester A has a write pending.
- A_Ready  output  1  A's write accepted this cycle.
- A_Reg_Num  input  REG_ADDR_W  A destination register.
- A_Data  input  DATA_W  A write data.
- B_Valid  input  1  requester B has a write pending.
- B_Ready  output  1  B's write accepted this cycle.
- B_Reg_Num  input  REG_ADDR_W  B destination register.
- B_Data  input  DATA_W  B write data.
- RF_Write_Reg_Num  output  REG_ADDR_W  register file write address (registered).
- RF_Write_Data  output  DATA_W  register file write data (registered).
- RF_RegWrite  output  1  register file write enable (registered).
- Init_Busy  output  1  high while the init pass runs; no requests accepted.
- Last_Grant_B  output  1  1 = most recent grant went to B.

Behaviour:
- One clock domain. Reset is asynchronous and active-low: the clock port is Clk, the reset port is Reset_n.
- Reset values while Reset_n=0:
  - RF_RegWrite=0, RF_Write_Reg_Num=0, RF_Write_Data=0.
  - Init_Busy=1, Last_Grant_B=0, A_Ready=0, B_Ready=0.
  - state=INIT, init counter=0.
- States: INIT, ARB.
- INIT:
  - At each rising edge, load RF_Write_Reg_Num=cnt, RF_Write_Data=cnt (zero-extended to DATA_W), RF_RegWrite=1, then cnt++.
  - The edge that loads cnt=NUM_REGS-1 also moves state to ARB and clears Init_Busy.
  - RF_RegWrite is therefore high for exactly NUM_REGS consecutive cycles, starting after the first edge following reset release.
  - A_Ready=B_Ready=0 throughout INIT; Valid inputs are ignored.
- ARB, Ready signals are combinational from state, Valids and the priority pointer:
  - Only A_Valid: A_Ready=1.
  - Only B_Valid: B_Ready=1.
  - Both valid: grant B if Last_Grant_B=0, otherwise grant A.
  - Never both Readys high in the same cycle.
- Transfer occurs when Valid&&Ready at a rising edge. On that edge:
  - RF outputs load the winner's Reg_Num/Data, RF_RegWrite=1.
  - Last_Grant_B = (winner==B).
- Edge with no transfer: RF_RegWrite=0; RF_Write_Reg_Num/Data hold their values.
- Latency: write visible on RF_* exactly one cycle after the accepting edge. Throughput: one write per cycle.
- Requesters hold Valid, Reg_Num and Data stable until accepted. Dropping Valid before acceptance withdraws the request; no write occurs.
- Both requesters targeting the same register in the same cycle: the winner is written first, the loser on a later cycle. The final value is the loser's data.
- Continuous contention alternates A,B,A,B,... regardless of register numbers.
- Reset asserted mid-INIT or mid-ARB:
  - All state clears immediately, without waiting for a clock edge.
  - Any in-flight RF_RegWrite drops to 0 at once.
  - After release, the full init pass reruns from reg 0.
  - Pending unaccepted requests are not retained.

Optional Feature:
- Macro: RF_ARB_FIXED_PRIO_EN.
- Defined: A always wins when both are valid. Last_Grant_B still records the actual winner. B can starve under sustained A traffic, which is the intended behaviour for writeback-critical builds.
- Undefined (default): round-robin as described above.

Test Plan:
- Release Reset_n, no requests -> RF_RegWrite high for 8 cycles with (Reg,Data) = (0,0),(1,1)..(7,7); Init_Busy falls on the edge writing reg 7; Readys stay 0 throughout.
- Raise A_Valid during INIT with A_Reg_Num=3, A_Data=0xAA -> no acceptance until ARB; then A_Ready=1 on the first ARB cycle and RF outputs (3,0xAA) with RF_RegWrite=1 one cycle later.
- A and B both valid continuously, A=(2,0x11), B=(5,0x22), Last_Grant_B=0 -> grants B,A,B,A; RF_RegWrite stays high every cycle; Last_Grant_B toggles 1,0,1,0.
- Both valid targeting reg 4, A=0x33, B=0x44, Last_Grant_B=1 -> A written first, B next cycle; final reg 4 value is 0x44.
- Assert Reset_n=0 asynchronously mid-ARB while RF_RegWrite=1 -> RF_RegWrite drops immediately; after release, init sequence 0..7 repeats in full.
- With RF_ARB_FIXED_PRIO_EN defined, both valid for 4 cycles -> A granted all 4 cycles, B_Ready stays 0; B is granted on the first cycle A_Valid=0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: owns the single write port of the register file.
// After reset it writes reg[i] = i for every register, one per cycle. It then
// shares the port between requester A (writeback) and requester B (debug/load)
// using valid/ready handshakes. The write-port outputs are registered.
//
// Build option: define RF_ARB_FIXED_PRIO_EN to give A fixed priority over B.
// Leave it undefined (the default) for round-robin arbitration.
//
// state   | meaning
// --------+---------------------------------------------------------
// INIT    | initialisation pass, writes reg[cnt] = cnt, no grants
// ARB     | arbitrate A/B, one accepted write per cycle

module rf_write_arbiter #(
    parameter int NUM_REGS   = 8,
    parameter int REG_ADDR_W = 3,
    parameter int DATA_W     = 8
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  A_Valid,
    output logic                  A_Ready,
    input  logic [REG_ADDR_W-1:0] A_Reg_Num,
    input  logic [DATA_W-1:0]     A_Data,
    input  logic                  B_Valid,
    output logic                  B_Ready,
    input  logic [REG_ADDR_W-1:0] B_Reg_Num,
    input  logic [DATA_W-1:0]     B_Data,
    output logic [REG_ADDR_W-1:0] RF_Write_Reg_Num,
    output logic [DATA_W-1:0]     RF_Write_Data,
    output logic                  RF_RegWrite,
    output logic                  Init_Busy,
    output logic                  Last_Grant_B
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_ARB  = 1'b1;

    logic [0:0]            state;
    logic [REG_ADDR_W-1:0] init_cnt;
    logic                  prefer_b;

`ifdef RF_ARB_FIXED_PRIO_EN
    // A always wins contention; Last_Grant_B is still tracked for observers.
    assign prefer_b = 1'b0;
`else
    // Round-robin: B wins contention unless it won the previous grant.
    assign prefer_b = ~Last_Grant_B;
`endif

    assign Init_Busy = (state == ST_INIT);

    // Grant decode. At most one Ready is high, and neither is high during INIT.
    always_comb begin
        A_Ready = 1'b0;
        B_Ready = 1'b0;
        if (state == ST_ARB) begin
            if (A_Valid && B_Valid) begin
                A_Ready = ~prefer_b;
                B_Ready = prefer_b;
            end else begin
                A_Ready = A_Valid;
                B_Ready = B_Valid;
            end
        end
    end

    // Sequencer: step through every register once, then hand over to arbitration.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == REG_ADDR_W'(NUM_REGS - 1)) begin
                state <= ST_ARB;
            end
        end
    end

    // Registered write port. Address and data hold their values on idle cycles.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            RF_RegWrite      <= 1'b0;
            RF_Write_Reg_Num <= '0;
            RF_Write_Data    <= '0;
        end else if (state == ST_INIT) begin
            RF_RegWrite      <= 1'b1;
            RF_Write_Reg_Num <= init_cnt;
            RF_Write_Data    <= DATA_W'(init_cnt);
        end else if (A_Ready) begin
            RF_RegWrite      <= 1'b1;
            RF_Write_Reg_Num <= A_Reg_Num;
            RF_Write_Data    <= A_Data;
        end else if (B_Ready) begin
            RF_RegWrite      <= 1'b1;
            RF_Write_Reg_Num <= B_Reg_Num;
            RF_Write_Data    <= B_Data;
        end else begin
            RF_RegWrite      <= 1'b0;
        end
    end

    // Record who received the most recent grant; this drives the fairness pointer.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Last_Grant_B <= 1'b0;
        end else if (A_Ready) begin
            Last_Grant_B <= 1'b0;
        end else if (B_Ready) begin
            Last_Grant_B <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter. Randomised requesters are checked against a
// cycle-level reference model. The bench also runs directed scenarios: the init
// pass, contention, a same-register collision and an asynchronous reset.
// The model honours RF_ARB_FIXED_PRIO_EN when it is defined.

module tb_rf_write_arbiter;

    localparam int NUM_REGS   = 8;
    localparam int REG_ADDR_W = 3;
    localparam int DATA_W     = 8;

    logic                  Clk = 1'b0;
    logic                  Reset_n = 1'b0;
    logic                  A_Valid = 1'b0, B_Valid = 1'b0;
    logic                  A_Ready, B_Ready;
    logic [REG_ADDR_W-1:0] A_Reg_Num = '0, B_Reg_Num = '0;
    logic [DATA_W-1:0]     A_Data = '0, B_Data = '0;
    logic [REG_ADDR_W-1:0] RF_Write_Reg_Num;
    logic [DATA_W-1:0]     RF_Write_Data;
    logic                  RF_RegWrite, Init_Busy, Last_Grant_B;

    rf_write_arbiter #(.NUM_REGS(NUM_REGS), .REG_ADDR_W(REG_ADDR_W), .DATA_W(DATA_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .A_Valid(A_Valid), .A_Ready(A_Ready), .A_Reg_Num(A_Reg_Num), .A_Data(A_Data),
        .B_Valid(B_Valid), .B_Ready(B_Ready), .B_Reg_Num(B_Reg_Num), .B_Data(B_Data),
        .RF_Write_Reg_Num(RF_Write_Reg_Num), .RF_Write_Data(RF_Write_Data),
        .RF_RegWrite(RF_RegWrite), .Init_Busy(Init_Busy), .Last_Grant_B(Last_Grant_B)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    // Requester intent: held stable until accepted, or withdrawn
    bit         a_v, b_v;
    logic [2:0] a_r, b_r;
    logic [7:0] a_d, b_d;

    // Reference model state
    int         m_init_done;
    bit         m_lgb;
    bit         m_we;
    logic [2:0] m_reg;
    logic [7:0] m_data;
    logic [7:0] m_rf [NUM_REGS];
    logic [7:0] dut_rf [NUM_REGS];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_init_done = 0;
        m_lgb  = 1'b0;
        m_we   = 1'b0;
        m_reg  = '0;
        m_data = '0;
        a_v = 1'b0;
        b_v = 1'b0;
    endtask

    task automatic randomise_reqs();
        if (!a_v && $urandom_range(0, 3) != 0) begin
            a_v = 1'b1; a_r = 3'($urandom); a_d = 8'($urandom);
        end else if (a_v && $urandom_range(0, 15) == 0) begin
            a_v = 1'b0;
        end
        if (!b_v && $urandom_range(0, 3) != 0) begin
            b_v = 1'b1; b_r = 3'($urandom); b_d = 8'($urandom);
        end else if (b_v && $urandom_range(0, 15) == 0) begin
            b_v = 1'b0;
        end
    endtask

    // One clock cycle. Call at a negedge; the task returns at the next negedge.
    task automatic step(input bit rnd);
        bit in_init, exp_a, exp_b, win_b;
        if (rnd) randomise_reqs();
        A_Valid = a_v; A_Reg_Num = a_r; A_Data = a_d;
        B_Valid = b_v; B_Reg_Num = b_r; B_Data = b_d;
        #1;
        in_init = (m_init_done < NUM_REGS);
        exp_a = 1'b0;
        exp_b = 1'b0;
        if (!in_init) begin
            if (a_v && b_v) begin
`ifdef RF_ARB_FIXED_PRIO_EN
                win_b = 1'b0;
`else
                win_b = !m_lgb;
`endif
                exp_a = !win_b;
                exp_b = win_b;
            end else begin
                exp_a = a_v;
                exp_b = b_v;
            end
        end
        check_val("a_ready", A_Ready, exp_a);
        check_val("b_ready", B_Ready, exp_b);
        check_val("init_busy", Init_Busy, in_init);
        check_val("last_grant_b", Last_Grant_B, m_lgb);

        if (in_init) begin
            m_reg = 3'(m_init_done); m_data = 8'(m_init_done); m_we = 1'b1;
            m_init_done++;
        end else if (exp_a) begin
            m_reg = a_r; m_data = a_d; m_we = 1'b1; m_lgb = 1'b0; a_v = 1'b0;
        end else if (exp_b) begin
            m_reg = b_r; m_data = b_d; m_we = 1'b1; m_lgb = 1'b1; b_v = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (m_we) m_rf[m_reg] = m_data;

        @(posedge Clk);
        #1;
        check_val("rf_regwrite", RF_RegWrite, m_we);
        check_val("rf_reg_num", RF_Write_Reg_Num, m_reg);
        check_val("rf_data", RF_Write_Data, m_data);
        if (RF_RegWrite) dut_rf[RF_Write_Reg_Num] = RF_Write_Data;
        @(negedge Clk);
    endtask

    initial begin
        model_reset();
        a_r = '0; b_r = '0; a_d = '0; b_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            m_rf[i] = 8'hEE;
            dut_rf[i] = 8'hEE;
        end

        // Values held while reset is asserted
        repeat (2) @(negedge Clk);
        check_val("rst_regwrite", RF_RegWrite, 1'b0);
        check_val("rst_reg_num", RF_Write_Reg_Num, 3'd0);
        check_val("rst_data", RF_Write_Data, 8'd0);
        check_val("rst_init_busy", Init_Busy, 1'b1);
        check_val("rst_lgb", Last_Grant_B, 1'b0);
        Reset_n = 1'b1;

        // Init pass, with A requesting (3,0xAA) throughout
        a_v = 1'b1; a_r = 3'd3; a_d = 8'hAA;
        for (int i = 0; i < NUM_REGS; i++) step(1'b0);
        step(1'b0);
        check_val("first_arb_write_a", {RF_RegWrite, 5'(RF_Write_Reg_Num), RF_Write_Data}, {1'b1, 5'd3, 8'hAA});

        // Continuous contention A=(2,0x11), B=(5,0x22); Last_Grant_B is 0 here
        for (int i = 0; i < 4; i++) begin
            if (!a_v) begin a_v = 1'b1; a_r = 3'd2; a_d = 8'h11; end
            if (!b_v) begin b_v = 1'b1; b_r = 3'd5; b_d = 8'h22; end
            step(1'b0);
        end
        a_v = 1'b0; b_v = 1'b0;

        // Same-register collision on reg 4, after a B grant sets Last_Grant_B
        b_v = 1'b1; b_r = 3'd1; b_d = 8'h5A;
        step(1'b0);
        a_v = 1'b1; a_r = 3'd4; a_d = 8'h33;
        b_v = 1'b1; b_r = 3'd4; b_d = 8'h44;
        step(1'b0);
        step(1'b0);
        check_val("collision_reg4", dut_rf[4], 8'h44);

`ifdef RF_ARB_FIXED_PRIO_EN
        // Fixed priority: A wins four contended cycles, then B when A drops
        for (int i = 0; i < 4; i++) begin
            a_v = 1'b1; a_r = 3'd6; a_d = 8'(i);
            if (!b_v) begin b_v = 1'b1; b_r = 3'd7; b_d = 8'h77; end
            step(1'b0);
        end
        step(1'b0);
        check_val("fixed_b_after_a", dut_rf[7], 8'h77);
`endif

        // Randomised traffic
        for (int i = 0; i < 300; i++) step(1'b1);

        // Asynchronous reset while a write is in flight
        a_v = 1'b1; a_r = 3'd0; a_d = 8'hC3; b_v = 1'b0;
        step(1'b0);
        check_val("pre_reset_we", RF_RegWrite, 1'b1);
        #2;
        Reset_n = 1'b0;
        #1;
        check_val("async_rst_we", RF_RegWrite, 1'b0);
        check_val("async_rst_busy", Init_Busy, 1'b1);
        check_val("async_rst_lgb", Last_Grant_B, 1'b0);
        @(negedge Clk);
        model_reset();
        Reset_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) step(1'b0);

        // Further random traffic after the rerun init pass
        for (int i = 0; i < 200; i++) step(1'b1);

        for (int i = 0; i < NUM_REGS; i++) check_val("rf_contents", dut_rf[i], m_rf[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
